// File: rtl/program_loader_if.sv
//==============================================================================
// Module      : program_loader_if
// Description : Stream, core-load, run-control and status bundle of the loader.
// Revision    : 1.0
//==============================================================================
`default_nettype none

interface program_loader_if #(
    parameter int ADDR_W = 20
);
    logic              IN_VALID;
    logic              IN_READY;
    logic [31:0]       IN_DATA;
    logic              CLR;
    logic              CORE_OK;
    logic              LOAD_PROGRAM_CTRL;
    logic [ADDR_W-1:0] LOAD_PROGRAM_ADDR;
    logic [31:0]       LOAD_PROGRAM_DATA;
    logic              LOAD_DATA_CTRL;
    logic [ADDR_W-1:0] LOAD_DATA_ADDR;
    logic [31:0]       LOAD_DATA_DATA;
    logic              START;
    logic              DONE;
    logic              ERR;
    logic [1:0]        ERR_CODE;

    modport master (
        input  IN_VALID, IN_DATA, CLR, CORE_OK,
        output IN_READY,
        output LOAD_PROGRAM_CTRL, LOAD_PROGRAM_ADDR, LOAD_PROGRAM_DATA,
        output LOAD_DATA_CTRL, LOAD_DATA_ADDR, LOAD_DATA_DATA,
        output START, DONE, ERR, ERR_CODE
    );

    modport slave (
        output IN_VALID, IN_DATA, CLR, CORE_OK,
        input  IN_READY,
        input  LOAD_PROGRAM_CTRL, LOAD_PROGRAM_ADDR, LOAD_PROGRAM_DATA,
        input  LOAD_DATA_CTRL, LOAD_DATA_ADDR, LOAD_DATA_DATA,
        input  START, DONE, ERR, ERR_CODE
    );
endinterface

`default_nettype wire

// File: rtl/program_loader.sv
//==============================================================================
// Module      : program_loader
// Description : Streams header/program/data words into core memories, then runs
//               the core and reports DONE or ERR. Optional trailer checksum via
//               macro PROGRAM_LOADER_CHECKSUM_EN.
// Revision    : 1.0
//==============================================================================
`default_nettype none

module program_loader #(
    parameter int ADDR_W         = 20,
    parameter int ADDR_STEP      = 1,
    parameter int MAX_WORDS      = 4096,
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic             CLK,
    input  logic             RST,
    program_loader_if.master bus
);
    typedef enum logic [3:0] {
        S_IDLE   = 4'd0,
        S_HDR_P  = 4'd1,
        S_HDR_D  = 4'd2,
        S_LOAD_P = 4'd3,
        S_LOAD_D = 4'd4,
`ifdef PROGRAM_LOADER_CHECKSUM_EN
        S_CHK    = 4'd5,
`endif
        S_RUN    = 4'd6,
        S_DONE   = 4'd7,
        S_ERR    = 4'd8
    } state_t;

`ifdef PROGRAM_LOADER_CHECKSUM_EN
    localparam state_t S_POST = S_CHK;
`else
    localparam state_t S_POST = S_RUN;
`endif
    localparam logic [31:0]       C_MAX_WORDS = 32'(MAX_WORDS);
    localparam logic [31:0]       C_TIMEOUT   = 32'(TIMEOUT_CYCLES);
    localparam logic [ADDR_W-1:0] C_STEP      = ADDR_W'(ADDR_STEP);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] p_cnt_q, p_cnt_d, d_cnt_q, d_cnt_d, wcnt_q, wcnt_d;
    logic [ADDR_W-1:0] p_addr_q, p_addr_d, d_addr_q, d_addr_d;
    logic [31:0]       cyc_q, cyc_d;
    logic [1:0]        err_code_q, err_code_d;
    logic              pctrl_q, pctrl_d, dctrl_q, dctrl_d;
    logic [ADDR_W-1:0] pa_out_q, pa_out_d, da_out_q, da_out_d;
    logic [31:0]       pd_out_q, pd_out_d, dd_out_q, dd_out_d;
    logic [31:0]       csum_q, csum_d;
    logic              w_ready, w_xfer;
    logic [ADDR_W-1:0] w_hdr;

    assign w_ready = (state_q == S_HDR_P) || (state_q == S_HDR_D) ||
                     (state_q == S_LOAD_P) || (state_q == S_LOAD_D)
`ifdef PROGRAM_LOADER_CHECKSUM_EN
                     || (state_q == S_CHK)
`endif
                     ;
    assign w_xfer  = bus.IN_VALID & w_ready;
    assign w_hdr   = bus.IN_DATA[ADDR_W-1:0];

    always_comb begin
        state_d    = state_q;
        p_cnt_d    = p_cnt_q;
        d_cnt_d    = d_cnt_q;
        wcnt_d     = wcnt_q;
        p_addr_d   = p_addr_q;
        d_addr_d   = d_addr_q;
        cyc_d      = cyc_q;
        err_code_d = err_code_q;
        pctrl_d    = 1'b0;
        dctrl_d    = 1'b0;
        pa_out_d   = pa_out_q;
        da_out_d   = da_out_q;
        pd_out_d   = pd_out_q;
        dd_out_d   = dd_out_q;
        csum_d     = csum_q;
        case (state_q)
            S_IDLE: begin
                state_d    = S_HDR_P;
                p_cnt_d    = '0;
                d_cnt_d    = '0;
                wcnt_d     = '0;
                p_addr_d   = '0;
                d_addr_d   = '0;
                cyc_d      = '0;
                err_code_d = 2'd0;
                csum_d     = '0;
            end
            S_HDR_P: if (w_xfer) begin
                p_cnt_d = w_hdr;
                state_d = S_HDR_D;
            end
            S_HDR_D: if (w_xfer) begin
                d_cnt_d = w_hdr;
                if (32'(p_cnt_q) > C_MAX_WORDS || 32'(w_hdr) > C_MAX_WORDS) begin
                    state_d    = S_ERR;
                    err_code_d = 2'd1;
                end else if (p_cnt_q != '0) begin
                    state_d = S_LOAD_P;
                end else if (w_hdr != '0) begin
                    state_d = S_LOAD_D;
                end else begin
                    state_d = S_POST;
                end
            end
            S_LOAD_P: if (w_xfer) begin
                pctrl_d  = 1'b1;
                pa_out_d = p_addr_q;
                pd_out_d = bus.IN_DATA;
                p_addr_d = p_addr_q + C_STEP;
                csum_d   = csum_q ^ bus.IN_DATA;
                if (wcnt_q + 1'b1 == p_cnt_q) begin
                    wcnt_d  = '0;
                    state_d = (d_cnt_q != '0) ? S_LOAD_D : S_POST;
                end else begin
                    wcnt_d = wcnt_q + 1'b1;
                end
            end
            S_LOAD_D: if (w_xfer) begin
                dctrl_d  = 1'b1;
                da_out_d = d_addr_q;
                dd_out_d = bus.IN_DATA;
                d_addr_d = d_addr_q + C_STEP;
                csum_d   = csum_q ^ bus.IN_DATA;
                if (wcnt_q + 1'b1 == d_cnt_q) begin
                    wcnt_d  = '0;
                    state_d = S_POST;
                end else begin
                    wcnt_d = wcnt_q + 1'b1;
                end
            end
`ifdef PROGRAM_LOADER_CHECKSUM_EN
            S_CHK: if (w_xfer) begin
                if (bus.IN_DATA == csum_q) begin
                    state_d = S_RUN;
                end else begin
                    state_d    = S_ERR;
                    err_code_d = 2'd3;
                end
            end
`endif
            S_RUN: begin
                cyc_d = cyc_q + 32'd1;
                // Completion takes priority over a timeout landing in the same cycle
                if (bus.CORE_OK) begin
                    state_d = S_DONE;
                end else if (C_TIMEOUT != 32'd0 && (cyc_q + 32'd1) >= C_TIMEOUT) begin
                    state_d    = S_ERR;
                    err_code_d = 2'd2;
                end
            end
            S_DONE, S_ERR: if (bus.CLR) begin
                state_d    = S_IDLE;
                err_code_d = 2'd0;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q    <= S_IDLE;
            p_cnt_q    <= '0;
            d_cnt_q    <= '0;
            wcnt_q     <= '0;
            p_addr_q   <= '0;
            d_addr_q   <= '0;
            cyc_q      <= '0;
            err_code_q <= 2'd0;
            pctrl_q    <= 1'b0;
            dctrl_q    <= 1'b0;
            pa_out_q   <= '0;
            da_out_q   <= '0;
            pd_out_q   <= '0;
            dd_out_q   <= '0;
            csum_q     <= '0;
        end else begin
            state_q    <= state_d;
            p_cnt_q    <= p_cnt_d;
            d_cnt_q    <= d_cnt_d;
            wcnt_q     <= wcnt_d;
            p_addr_q   <= p_addr_d;
            d_addr_q   <= d_addr_d;
            cyc_q      <= cyc_d;
            err_code_q <= err_code_d;
            pctrl_q    <= pctrl_d;
            dctrl_q    <= dctrl_d;
            pa_out_q   <= pa_out_d;
            da_out_q   <= da_out_d;
            pd_out_q   <= pd_out_d;
            dd_out_q   <= dd_out_d;
            csum_q     <= csum_d;
        end
    end

    assign bus.IN_READY          = w_ready;
    assign bus.LOAD_PROGRAM_CTRL = pctrl_q;
    assign bus.LOAD_PROGRAM_ADDR = pa_out_q;
    assign bus.LOAD_PROGRAM_DATA = pd_out_q;
    assign bus.LOAD_DATA_CTRL    = dctrl_q;
    assign bus.LOAD_DATA_ADDR    = da_out_q;
    assign bus.LOAD_DATA_DATA    = dd_out_q;
    // The final write strobe trails the last transfer by a cycle; hold START off until it clears
    assign bus.START             = (state_q == S_RUN) & ~pctrl_q & ~dctrl_q;
    assign bus.DONE              = (state_q == S_DONE);
    assign bus.ERR               = (state_q == S_ERR);
    assign bus.ERR_CODE          = err_code_q;
endmodule

`default_nettype wire
